inst_fetch_queue: RTL and testbench
===================================

// Module: inst_fetch_queue
// PURPOSE
//  Fetch stage upstream of the instruction memory and the decode/issue logic.
//  - Owns the program counter (PC) and drives the instruction-memory address.
//  - Captures the combinationally returned instruction word into a small FIFO,
//    tagged with its PC.
//  - Presents the FIFO head to decode over a valid/ready handshake.
//  - Supports a redirect (flush plus new PC) for squash/branch recovery.
// PARAMETERS
//  QUEUE_DEPTH      4                 FIFO entries; power of two, >= 2
//  QUEUE_DEPTH_LOG  2                 log2(QUEUE_DEPTH)
//  `MEMI_SIZE_LOG   (param.v)         PC / memory address width
//  `INST_LEN        (param.v)         instruction word width
// PORTS
//  clk            in   1                       clock; all state updates on posedge
//  rst            in   1                       asynchronous, active-low reset
//  fetch_en       in   1                       1 = fetching allowed this cycle
//  redirect_valid in   1                       flush queue and load redirect_pc
//  redirect_pc    in   `MEMI_SIZE_LOG          new fetch PC
//  memi_req_addr  out  `MEMI_SIZE_LOG          instruction-memory address (= pc)
//  memi_resp_data in   `INST_LEN               instruction at memi_req_addr, same cycle
//  out_valid      out  1                       FIFO head valid
//  out_ready      in   1                       decode accepts head
//  out_inst       out  `INST_LEN               head instruction
//  out_pc         out  `MEMI_SIZE_LOG          head PC
//  count          out  QUEUE_DEPTH_LOG+1       current occupancy, 0..QUEUE_DEPTH
// BEHAVIOUR
//  Reset (rst==0, asynchronous):
//  - pc=0, head=tail=0, count=0, out_valid=0, out_inst=0, out_pc=0.
//  - Release is taken synchronously at the next posedge.
//  Address path:
//  - memi_req_addr = pc, driven straight from the register.
//  - Memory read is combinational: fetch latency is zero cycles; an instruction
//    enters the queue on the edge that ends the cycle its address is driven.
//  Dequeue:
//  - deq = out_valid & out_ready.
//  - out_valid = (count!=0). out_inst/out_pc come from the head entry; both are
//    0 when empty.
//  - Outputs hold stable while out_valid & !out_ready.
//  Enqueue:
//  - enq = fetch_en & !redirect_valid & (count<QUEUE_DEPTH | deq).
//  - A full queue accepts a new entry in the same cycle it is dequeued.
//  - On enq, at the posedge: entry[tail] <= {memi_resp_data, pc};
//    tail <= tail+1 (wraps mod QUEUE_DEPTH); pc <= pc+1 (wraps mod 2^`MEMI_SIZE_LOG).
//  - Without enq, pc holds.
//  Occupancy:
//  - count next = count + enq - deq.
//  - enq & deq on an empty queue is illegal and cannot happen, because
//    out_valid is 0 when empty. There is no bypass: a fetched instruction
//    reaches out_valid one cycle after it is fetched.
//  Redirect (priority over enqueue):
//  - Any deq in the same cycle still completes; decode has consumed that head.
//  - At the posedge: every entry is invalidated (head=tail=0, count=0) and
//    pc <= redirect_pc. No enqueue happens that cycle.
//  - First fetch from redirect_pc is the next cycle, if fetch_en=1.
//  fetch_en=0: no enqueue and pc holds; dequeue continues normally.
//  Reset mid-operation: asynchronously returns all state to reset values;
//  queued instructions are lost.
//  No other state machine: the block is a PC register plus a circular FIFO.
// TESTING
//  1 Reset, then fetch_en=1, out_ready=1, memory word[i]=i+16
//    -> out_valid first seen cycle 1; out_pc = 0,1,2,... with out_inst=16,17,...,
//    one per cycle.
//  2 out_ready=0, fetch_en=1
//    -> count goes 1,2,3,4 then holds; pc stops at 4; out_pc stays 0.
//    Then out_ready=1 for 1 cycle -> head pc 1, count stays 4, pc=5.
//  3 Redirect with redirect_pc=6 while count=3 and deq=1
//    -> next cycle count=0, out_valid=0, pc=6; the following cycle out_pc=6.
//  4 Wrap: start at pc=2^`MEMI_SIZE_LOG-1 via redirect
//    -> entries pc=max then pc=0; tail wraps past QUEUE_DEPTH-1 correctly.
//  5 fetch_en=0 for 3 cycles with queue partially full, out_ready=1
//    -> queue drains to 0, pc unchanged.
//  6 Assert rst low mid-stream (not on an edge)
//    -> out_valid=0, count=0, memi_req_addr=0 immediately.
//    After release, fetch resumes from pc 0.

Source files
------------

// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus: PC/redirect control, instruction-memory request/response and
// the decode-side valid/ready handshake carrying the queue head.
interface inst_fetch_queue_if #(
  parameter int MEMI_SIZE_LOG   = 6,
  parameter int INST_LEN        = 32,
  parameter int QUEUE_DEPTH_LOG = 2
);
  logic                       fetch_en;
  logic                       redirect_valid;
  logic [MEMI_SIZE_LOG-1:0]   redirect_pc;
  logic [MEMI_SIZE_LOG-1:0]   memi_req_addr;
  logic [INST_LEN-1:0]        memi_resp_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [INST_LEN-1:0]        out_inst;
  logic [MEMI_SIZE_LOG-1:0]   out_pc;
  logic [QUEUE_DEPTH_LOG:0]   count;

  modport master (
    input  fetch_en, redirect_valid, redirect_pc, memi_resp_data, out_ready,
    output memi_req_addr, out_valid, out_inst, out_pc, count
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_pc, memi_resp_data, out_ready,
    input  memi_req_addr, out_valid, out_inst, out_pc, count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Fetch stage: PC register driving a combinational instruction memory, plus a
// circular FIFO of {instruction, pc} entries presented to decode.
module inst_fetch_queue #(
  parameter int QUEUE_DEPTH     = 4,
  parameter int QUEUE_DEPTH_LOG = 2,
  parameter int MEMI_SIZE_LOG   = 6,
  parameter int INST_LEN        = 32
) (
  input  logic clk,
  input  logic rst,
  inst_fetch_queue_if.master bus
);
  localparam int CNT_W = QUEUE_DEPTH_LOG + 1;

  logic [MEMI_SIZE_LOG-1:0]   pc_q, pc_d;
  logic [QUEUE_DEPTH_LOG-1:0] head_q, head_d;
  logic [QUEUE_DEPTH_LOG-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]           count_q, count_d;

  logic [INST_LEN-1:0]        inst_q [QUEUE_DEPTH];
  logic [INST_LEN-1:0]        inst_d [QUEUE_DEPTH];
  logic [MEMI_SIZE_LOG-1:0]   epc_q  [QUEUE_DEPTH];
  logic [MEMI_SIZE_LOG-1:0]   epc_d  [QUEUE_DEPTH];

  logic not_empty;
  logic full;
  logic deq;
  logic enq;

  function automatic logic [QUEUE_DEPTH_LOG-1:0] ptr_inc(input logic [QUEUE_DEPTH_LOG-1:0] p);
    ptr_inc = p + QUEUE_DEPTH_LOG'(1);
  endfunction

  always_comb begin
    not_empty = (count_q != '0);
    full      = (count_q == CNT_W'(QUEUE_DEPTH));
    deq       = not_empty & bus.out_ready;
    // A full queue may still take a word when its head leaves this cycle.
    enq       = bus.fetch_en & ~bus.redirect_valid & (~full | deq);
  end

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (deq) head_d = ptr_inc(head_q);
      if (enq) begin
        tail_d = ptr_inc(tail_q);
        pc_d   = pc_q + MEMI_SIZE_LOG'(1);
      end
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  always_comb begin
    inst_d = inst_q;
    epc_d  = epc_q;
    if (enq) begin
      inst_d[tail_q] = bus.memi_resp_data;
      epc_d[tail_q]  = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is never read while invalid, so it carries no reset.
  always_ff @(posedge clk) begin
    inst_q <= inst_d;
    epc_q  <= epc_d;
  end

  assign bus.memi_req_addr = pc_q;
  assign bus.out_valid     = not_empty;
  assign bus.out_inst      = not_empty ? inst_q[head_q] : '0;
  assign bus.out_pc        = not_empty ? epc_q[head_q]  : '0;
  assign bus.count         = count_q;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised scoreboard bench for inst_fetch_queue against a queue-based model.
module tb_inst_fetch_queue;
  localparam int DEPTH = 4;
  localparam int DLOG  = 2;
  localparam int MW    = 6;
  localparam int IW    = 32;

  typedef struct {
    logic [IW-1:0] inst;
    logic [MW-1:0] pc;
  } ent_t;

  logic clk;
  logic rst;
  inst_fetch_queue_if #(.MEMI_SIZE_LOG(MW), .INST_LEN(IW), .QUEUE_DEPTH_LOG(DLOG)) bus ();

  inst_fetch_queue #(
    .QUEUE_DEPTH(DEPTH), .QUEUE_DEPTH_LOG(DLOG), .MEMI_SIZE_LOG(MW), .INST_LEN(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [IW-1:0] salt;
  assign bus.memi_resp_data = IW'(bus.memi_req_addr) + 32'd16 + salt;

  ent_t          exp_q[$];
  int            cur_cnt;
  logic [MW-1:0] cur_pc;
  bit            pend_flush;
  bit            rand_salt;
  int            n_checks;
  int            n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: check state left by the previous edge, drive inputs, advance the model.
  task automatic cycle(input bit fe, input bit rv, input logic [MW-1:0] rpc, input bit rdy);
    bit deq, enq;
    @(posedge clk);
    #1;
    if (pend_flush) begin
      exp_q.delete();
      pend_flush = 1'b0;
    end
    chk("count", 64'(bus.count), 64'(cur_cnt));
    chk("pc", 64'(bus.memi_req_addr), 64'(cur_pc));
    chk("out_valid", 64'(bus.out_valid), 64'(cur_cnt != 0));
    if (rand_salt && $urandom_range(0, 9) == 0) salt = $urandom;
    bus.fetch_en       = fe;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
    deq = (cur_cnt != 0) && rdy;
    enq = fe && !rv && (cur_cnt < DEPTH || deq);
    if (rv) begin
      cur_cnt    = 0;
      cur_pc     = rpc;
      pend_flush = 1'b1;
    end else begin
      if (enq) begin
        exp_q.push_back('{inst: IW'(cur_pc) + 32'd16 + salt, pc: cur_pc});
        cur_pc = cur_pc + 1'b1;
      end
      cur_cnt = cur_cnt + int'(enq) - int'(deq);
    end
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_addr", 64'(bus.memi_req_addr), 64'd0);
    exp_q.delete();
    cur_cnt    = 0;
    cur_pc     = '0;
    pend_flush = 1'b0;
    bus.fetch_en       = 1'b0;
    bus.redirect_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  // Monitor: compares the presented head against the scoreboard every cycle.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (rst && bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 64'd1, 64'd0);
        end else begin
          if (bus.out_ready) e = exp_q.pop_front();
          else e = exp_q[0];
          chk("out_inst", 64'(bus.out_inst), 64'(e.inst));
          chk("out_pc", 64'(bus.out_pc), 64'(e.pc));
        end
      end else if (!bus.out_valid) begin
        chk("empty_inst", 64'(bus.out_inst), 64'd0);
        chk("empty_pc", 64'(bus.out_pc), 64'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    salt     = '0;
    rand_salt = 1'b0;
    cur_cnt  = 0;
    cur_pc   = '0;
    pend_flush = 1'b0;
    rst = 1'b0;
    bus.fetch_en       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_count", 64'(bus.count), 64'd0);
    chk("reset_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_addr", 64'(bus.memi_req_addr), 64'd0);
    chk("reset_inst", 64'(bus.out_inst), 64'd0);
    chk("reset_pc", 64'(bus.out_pc), 64'd0);
    rst = 1'b1;

    // Streaming with decode always ready.
    repeat (8) cycle(1'b1, 1'b0, '0, 1'b1);
    // Back-pressure from an empty queue, then a single accept while full.
    cycle(1'b0, 1'b1, '0, 1'b1);
    repeat (6) cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1);
    repeat (2) cycle(1'b1, 1'b0, '0, 1'b0);
    // Redirect with a concurrent dequeue.
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b1, MW'(6), 1'b1);
    repeat (4) cycle(1'b1, 1'b0, '0, 1'b1);
    // PC wrap from the top of the address space.
    cycle(1'b1, 1'b1, {MW{1'b1}}, 1'b0);
    repeat (6) cycle(1'b1, 1'b0, '0, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, '0, 1'b1);
    // Fetch disabled while draining.
    cycle(1'b1, 1'b0, '0, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, '0, 1'b1);

    rand_salt = 1'b1;
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
            MW'($urandom), $urandom_range(0, 9) < 6);
    end

    // Asynchronous reset mid-stream, then resume from pc 0.
    repeat (3) cycle(1'b1, 1'b0, '0, 1'b0);
    mid_reset();
    repeat (6) cycle(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
            MW'($urandom), $urandom_range(0, 1) == 1);
    end

    repeat (DEPTH + 2) cycle(1'b0, 1'b0, '0, 1'b1);
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
